// File: rtl/mmu_pkg.sv
// Shared definitions for the segment MMU: configuration field codes,
// FSM state encoding, fault cause codes and mode constants.
package mmu_pkg;

   // Bound register selected by cfg_field
   localparam logic [1:0] FIELD_LOWER_IM = 2'd0;
   localparam logic [1:0] FIELD_UPPER_IM = 2'd1;
   localparam logic [1:0] FIELD_LOWER_DM = 2'd2;
   localparam logic [1:0] FIELD_UPPER_DM = 2'd3;

   // Protection state of the MMU
   typedef enum logic [1:0] {
      ST_KERNEL = 2'd0,
      ST_USER   = 2'd1,
      ST_FAULT  = 2'd2
   } state_t;

   // Reported fault cause; bit 0 is the instruction channel, bit 1 the data channel
   localparam logic [1:0] CAUSE_NONE = 2'b00;
   localparam logic [1:0] CAUSE_IM   = 2'b01;
   localparam logic [1:0] CAUSE_DM   = 2'b10;
   localparam logic [1:0] CAUSE_BOTH = 2'b11;

   // Value presented on the mode output
   localparam logic MODE_KERNEL = 1'b0;
   localparam logic MODE_USER   = 1'b1;

endpackage

// File: rtl/mmu_seg_if.sv
// Bus between the processor side (master) and the segment MMU (slave).
// Carries bound-table configuration, selector load, mode requests, both
// translation channels and the fault report.
interface mmu_seg_if #(
   parameter int ADDR_W   = 26,
   parameter int DATA_W   = 32,
   parameter int NUM_SEGS = 16
) ();
   localparam int SEL_W = $clog2(NUM_SEGS);

   logic              cfg_we;
   logic [1:0]        cfg_field;
   logic [SEL_W-1:0]  cfg_sel;
   logic [DATA_W-1:0] cfg_data;
   logic              sel_we;
   logic [DATA_W-1:0] sel_in;
   logic              user_mode;
   logic              kernel_mode;
   logic              im_req;
   logic [ADDR_W-1:0] im_addr_in;
   logic              im_valid;
   logic [ADDR_W-1:0] im_addr_out;
   logic              dm_req;
   logic [ADDR_W-1:0] dm_addr_in;
   logic              dm_valid;
   logic [ADDR_W-1:0] dm_addr_out;
   logic              fault;
   logic [1:0]        fault_cause;
   logic [ADDR_W-1:0] fault_addr;
   logic              mode;

   modport master (
      output cfg_we, cfg_field, cfg_sel, cfg_data, sel_we, sel_in,
             user_mode, kernel_mode, im_req, im_addr_in, dm_req, dm_addr_in,
      input  im_valid, im_addr_out, dm_valid, dm_addr_out,
             fault, fault_cause, fault_addr, mode
   );

   modport slave (
      input  cfg_we, cfg_field, cfg_sel, cfg_data, sel_we, sel_in,
             user_mode, kernel_mode, im_req, im_addr_in, dm_req, dm_addr_in,
      output im_valid, im_addr_out, dm_valid, dm_addr_out,
             fault, fault_cause, fault_addr, mode
   );

endinterface

// File: rtl/mmu_xlate.sv
// One translation channel of the segment MMU: relocation adder, bound
// comparison and the registered address/valid output.
// MMU_BOUNDS_CHECK_EN: when defined, the upper bound and carry checks are
// built and a violation flag is reported to the parent.
module mmu_xlate
   import mmu_pkg::*;
#(
   parameter int ADDR_W = 26
) (
   input  logic              clk,
   input  logic              rst_n,
   input  state_t            state,
   input  logic              req,
   input  logic [ADDR_W-1:0] addr_in,
   input  logic [ADDR_W:0]   lower,
`ifdef MMU_BOUNDS_CHECK_EN
   input  logic [ADDR_W-1:0] upper,
   output logic              violation,
`endif
   output logic              valid,
   output logic [ADDR_W-1:0] addr_out
);

   // Two extra bits so any overflow past the address space is visible,
   // including the case where lower itself has its top bit set.
   logic [ADDR_W+1:0] sum;
   logic              out_of_bounds;

   assign sum = {2'b00, addr_in} + {1'b0, lower};

`ifdef MMU_BOUNDS_CHECK_EN
   assign out_of_bounds = (sum[ADDR_W+1:ADDR_W] != 2'b00) || (sum[ADDR_W-1:0] > upper);
   assign violation     = req && (state == ST_USER) && out_of_bounds;
`else
   logic [1:0] sum_carry_unused;
   assign sum_carry_unused = sum[ADDR_W+1:ADDR_W];
   assign out_of_bounds    = 1'b0;
`endif

   // Register the translated address one cycle after the request is sampled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid    <= 1'b0;
         addr_out <= '0;
      end else begin
         case (state)
            ST_KERNEL: begin
               valid    <= req;
               addr_out <= addr_in;
            end
            ST_USER: begin
               if (req && !out_of_bounds) begin
                  valid    <= 1'b1;
                  addr_out <= sum[ADDR_W-1:0];
               end else begin
                  valid    <= 1'b0;
                  addr_out <= '0;
               end
            end
            default: begin
               valid    <= 1'b0;
               addr_out <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/mmu_seg.sv
// Segment MMU with per-process base/limit registers. Holds the bound
// table, the active segment selector, the kernel/user/fault state machine
// and the sticky fault report; translation is done by two mmu_xlate
// channels (instruction and data).
// MMU_BOUNDS_CHECK_EN: when defined, upper bounds are stored and checked
// and faults are raised; otherwise only relocation is applied in user mode.
module mmu_seg
   import mmu_pkg::*;
#(
   parameter int ADDR_W   = 26,
   parameter int DATA_W   = 32,
   parameter int NUM_SEGS = 16
) (
   input logic      clk,
   input logic      rst_n,
   mmu_seg_if.slave bus
);

   localparam int SEL_W = $clog2(NUM_SEGS);

   // Only the bound bits the adder and comparator consume are stored
   logic [ADDR_W:0]   lower_im [NUM_SEGS];
   logic [ADDR_W:0]   lower_dm [NUM_SEGS];
`ifdef MMU_BOUNDS_CHECK_EN
   logic [ADDR_W-1:0] upper_im [NUM_SEGS];
   logic [ADDR_W-1:0] upper_dm [NUM_SEGS];
`endif

   logic [SEL_W-1:0]  sel_q;
   state_t            state_q;
   state_t            state_d;
   logic              im_viol;
   logic              dm_viol;

   logic [DATA_W-ADDR_W-2:0] cfg_data_unused;
   assign cfg_data_unused = bus.cfg_data[DATA_W-1:ADDR_W+1];

   // Bound table writes, accepted in any mode
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_SEGS; i++) begin
            lower_im[i] <= '0;
            lower_dm[i] <= '0;
`ifdef MMU_BOUNDS_CHECK_EN
            upper_im[i] <= '0;
            upper_dm[i] <= '0;
`endif
         end
      end else if (bus.cfg_we) begin
         case (bus.cfg_field)
            FIELD_LOWER_IM: lower_im[bus.cfg_sel] <= bus.cfg_data[ADDR_W:0];
            FIELD_LOWER_DM: lower_dm[bus.cfg_sel] <= bus.cfg_data[ADDR_W:0];
`ifdef MMU_BOUNDS_CHECK_EN
            FIELD_UPPER_IM: upper_im[bus.cfg_sel] <= bus.cfg_data[ADDR_W-1:0];
            FIELD_UPPER_DM: upper_dm[bus.cfg_sel] <= bus.cfg_data[ADDR_W-1:0];
`endif
            default: ;
         endcase
      end
   end

   // Active segment selector; out-of-range values are dropped
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_q <= '0;
      end else if (bus.sel_we && (bus.sel_in < DATA_W'(NUM_SEGS))) begin
         sel_q <= bus.sel_in[SEL_W-1:0];
      end
   end

   // State register of the protection FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_KERNEL;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: kernel_mode beats user_mode; a violation beats kernel_mode in USER
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_KERNEL: begin
            if (!bus.kernel_mode && bus.user_mode) begin
               state_d = ST_USER;
            end
         end
         ST_USER: begin
            if (im_viol || dm_viol) begin
               state_d = ST_FAULT;
            end else if (bus.kernel_mode) begin
               state_d = ST_KERNEL;
            end
         end
         ST_FAULT: begin
            if (bus.kernel_mode) begin
               state_d = ST_KERNEL;
            end
         end
         default: state_d = ST_KERNEL;
      endcase
   end

`ifdef MMU_BOUNDS_CHECK_EN
   logic              fault_q;
   logic [1:0]        cause_q;
   logic [ADDR_W-1:0] fault_addr_q;

   // Sticky fault report: latched on a violation, cleared when leaving FAULT
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fault_q      <= 1'b0;
         cause_q      <= CAUSE_NONE;
         fault_addr_q <= '0;
      end else if ((state_q == ST_FAULT) && bus.kernel_mode) begin
         fault_q      <= 1'b0;
         cause_q      <= CAUSE_NONE;
         fault_addr_q <= '0;
      end else if ((state_q == ST_USER) && (im_viol || dm_viol)) begin
         fault_q      <= 1'b1;
         cause_q      <= {dm_viol, im_viol};
         fault_addr_q <= im_viol ? bus.im_addr_in : bus.dm_addr_in;
      end
   end

   assign bus.fault       = fault_q;
   assign bus.fault_cause = cause_q;
   assign bus.fault_addr  = fault_addr_q;
`else
   assign im_viol         = 1'b0;
   assign dm_viol         = 1'b0;
   assign bus.fault       = 1'b0;
   assign bus.fault_cause = CAUSE_NONE;
   assign bus.fault_addr  = '0;
`endif

   assign bus.mode = (state_q == ST_USER) ? MODE_USER : MODE_KERNEL;

   mmu_xlate #(.ADDR_W(ADDR_W)) u_xlate_im (
      .clk       (clk),
      .rst_n     (rst_n),
      .state     (state_q),
      .req       (bus.im_req),
      .addr_in   (bus.im_addr_in),
      .lower     (lower_im[sel_q]),
`ifdef MMU_BOUNDS_CHECK_EN
      .upper     (upper_im[sel_q]),
      .violation (im_viol),
`endif
      .valid     (bus.im_valid),
      .addr_out  (bus.im_addr_out)
   );

   mmu_xlate #(.ADDR_W(ADDR_W)) u_xlate_dm (
      .clk       (clk),
      .rst_n     (rst_n),
      .state     (state_q),
      .req       (bus.dm_req),
      .addr_in   (bus.dm_addr_in),
      .lower     (lower_dm[sel_q]),
`ifdef MMU_BOUNDS_CHECK_EN
      .upper     (upper_dm[sel_q]),
      .violation (dm_viol),
`endif
      .valid     (bus.dm_valid),
      .addr_out  (bus.dm_addr_out)
   );

endmodule

// File: tb/tb_mmu_seg.sv
// Testbench for mmu_seg: directed scenarios followed by random traffic,
// all checked against a behavioural model of the segment MMU.
// Follows MMU_BOUNDS_CHECK_EN the same way the design does.
module tb_mmu_seg;

   localparam int ADDR_W   = 26;
   localparam int DATA_W   = 32;
   localparam int NUM_SEGS = 16;
   localparam longint unsigned SPACE      = 64'd1 << ADDR_W;
   localparam longint unsigned LOWER_MASK = (64'd1 << (ADDR_W + 1)) - 64'd1;
`ifdef MMU_BOUNDS_CHECK_EN
   localparam bit CHECKS = 1'b1;
`else
   localparam bit CHECKS = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   mmu_seg_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SEGS(NUM_SEGS)) bus ();

   mmu_seg #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SEGS(NUM_SEGS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   int n_vectors     = 0;
   int n_miscompares = 0;

   // Reference model state: 0 kernel, 1 user, 2 fault
   longint unsigned m_lower_im [NUM_SEGS];
   longint unsigned m_upper_im [NUM_SEGS];
   longint unsigned m_lower_dm [NUM_SEGS];
   longint unsigned m_upper_dm [NUM_SEGS];
   int              m_sel;
   int              m_state;
   logic            m_fault;
   logic [1:0]      m_cause;
   longint unsigned m_fault_addr;
   logic            e_im_valid;
   logic            e_dm_valid;
   longint unsigned e_im_addr;
   longint unsigned e_dm_addr;

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vectors++;
      if (got !== exp) begin
         n_miscompares++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic resetModel();
      for (int i = 0; i < NUM_SEGS; i++) begin
         m_lower_im[i] = 0;
         m_upper_im[i] = 0;
         m_lower_dm[i] = 0;
         m_upper_dm[i] = 0;
      end
      m_sel        = 0;
      m_state      = 0;
      m_fault      = 1'b0;
      m_cause      = 2'b00;
      m_fault_addr = 0;
      e_im_valid   = 1'b0;
      e_dm_valid   = 1'b0;
      e_im_addr    = 0;
      e_dm_addr    = 0;
   endtask

   // Result of one channel for the current mode: pass-through, relocate+check, or blocked
   task automatic modelXlate(input logic req, input longint unsigned a,
                             input longint unsigned lo, input longint unsigned up,
                             output logic v, output longint unsigned o, output logic bad);
      longint unsigned phys;
      v   = 1'b0;
      o   = 0;
      bad = 1'b0;
      if (m_state == 0) begin
         v = req;
         o = a;
      end else if (m_state == 1) begin
         phys = a + (lo & LOWER_MASK);
         if (CHECKS && req && (phys >= SPACE || phys > (up % SPACE))) bad = 1'b1;
         if (req && !bad) begin
            v = 1'b1;
            o = phys % SPACE;
         end
      end
   endtask

   task automatic checkAll(input string when);
      checkOutput({when, " im_valid"},    64'(bus.im_valid),    64'(e_im_valid));
      checkOutput({when, " im_addr_out"}, 64'(bus.im_addr_out), e_im_addr);
      checkOutput({when, " dm_valid"},    64'(bus.dm_valid),    64'(e_dm_valid));
      checkOutput({when, " dm_addr_out"}, 64'(bus.dm_addr_out), e_dm_addr);
      checkOutput({when, " mode"},        64'(bus.mode),        64'(m_state == 1));
      checkOutput({when, " fault"},       64'(bus.fault),       64'(m_fault));
      checkOutput({when, " fault_cause"}, 64'(bus.fault_cause), 64'(m_cause));
      checkOutput({when, " fault_addr"},  64'(bus.fault_addr),  m_fault_addr);
   endtask

   task automatic clearInputs();
      bus.cfg_we      = 1'b0;
      bus.cfg_field   = 2'd0;
      bus.cfg_sel     = '0;
      bus.cfg_data    = '0;
      bus.sel_we      = 1'b0;
      bus.sel_in      = '0;
      bus.user_mode   = 1'b0;
      bus.kernel_mode = 1'b0;
      bus.im_req      = 1'b0;
      bus.im_addr_in  = '0;
      bus.dm_req      = 1'b0;
      bus.dm_addr_in  = '0;
   endtask

   // Predict the edge from the currently driven inputs, clock it, compare
   task automatic applyStimulus(input string tag);
      logic            iv, dv, ib, db;
      longint unsigned ia, da;
      modelXlate(bus.im_req, bus.im_addr_in, m_lower_im[m_sel], m_upper_im[m_sel], iv, ia, ib);
      modelXlate(bus.dm_req, bus.dm_addr_in, m_lower_dm[m_sel], m_upper_dm[m_sel], dv, da, db);
      case (m_state)
         0: if (!bus.kernel_mode && bus.user_mode) m_state = 1;
         1: begin
            if (ib || db) begin
               m_state      = 2;
               m_fault      = 1'b1;
               m_cause      = {db, ib};
               m_fault_addr = ib ? longint'(bus.im_addr_in) : longint'(bus.dm_addr_in);
            end else if (bus.kernel_mode) begin
               m_state = 0;
            end
         end
         default: begin
            if (bus.kernel_mode) begin
               m_state      = 0;
               m_fault      = 1'b0;
               m_cause      = 2'b00;
               m_fault_addr = 0;
            end
         end
      endcase
      e_im_valid = iv;
      e_im_addr  = ia;
      e_dm_valid = dv;
      e_dm_addr  = da;
      if (bus.cfg_we) begin
         case (bus.cfg_field)
            2'd0:    m_lower_im[bus.cfg_sel] = bus.cfg_data;
            2'd1:    m_upper_im[bus.cfg_sel] = bus.cfg_data;
            2'd2:    m_lower_dm[bus.cfg_sel] = bus.cfg_data;
            default: m_upper_dm[bus.cfg_sel] = bus.cfg_data;
         endcase
      end
      if (bus.sel_we && bus.sel_in < NUM_SEGS) m_sel = int'(bus.sel_in);
      @(posedge clk);
      #1;
      checkAll(tag);
   endtask

   task automatic cfgWrite(input int seg, input int field, input longint unsigned data);
      clearInputs();
      bus.cfg_we    = 1'b1;
      bus.cfg_sel   = 4'(seg);
      bus.cfg_field = 2'(field);
      bus.cfg_data  = 32'(data);
      applyStimulus("cfg");
   endtask

   task automatic modeStep(input logic user, input logic kernel, input string tag);
      clearInputs();
      bus.user_mode   = user;
      bus.kernel_mode = kernel;
      applyStimulus(tag);
   endtask

   task automatic imReq(input longint unsigned a, input string tag);
      clearInputs();
      bus.im_req     = 1'b1;
      bus.im_addr_in = 26'(a);
      applyStimulus(tag);
   endtask

   longint unsigned rnd_data;
   int              rnd_field;

   initial begin
      rst_n = 1'b0;
      clearInputs();
      resetModel();
      repeat (2) @(posedge clk);
      #1;
      checkAll("reset");
      @(negedge clk);
      rst_n = 1'b1;

      imReq(64'h100, "kernel passthrough");

      cfgWrite(3, 0, 64'h1000);
      cfgWrite(3, 1, 64'h1FFF);
      cfgWrite(3, 2, 64'h0);
      cfgWrite(3, 3, 64'h4);
      clearInputs();
      bus.sel_we = 1'b1;
      bus.sel_in = 32'd3;
      applyStimulus("select seg3");
      modeStep(1'b1, 1'b0, "enter user");
      imReq(64'h0FFF, "upper bound exact");
      imReq(64'h1000, "upper bound plus one");
      modeStep(1'b0, 1'b1, "fault ack");

      modeStep(1'b1, 1'b0, "enter user 2");
      clearInputs();
      bus.im_req     = 1'b1;
      bus.im_addr_in = 26'h2000;
      bus.dm_req     = 1'b1;
      bus.dm_addr_in = 26'h5;
      applyStimulus("both channels");
      modeStep(1'b0, 1'b1, "fault ack 2");

      cfgWrite(3, 0, 64'h3FFFFFF);
      modeStep(1'b1, 1'b0, "enter user 3");
      imReq(64'h2, "carry out");
      modeStep(1'b0, 1'b1, "fault ack 3");
      clearInputs();
      bus.user_mode   = 1'b1;
      bus.kernel_mode = 1'b1;
      bus.im_req      = 1'b1;
      bus.im_addr_in  = 26'h77;
      applyStimulus("user and kernel");

      clearInputs();
      bus.sel_we = 1'b1;
      bus.sel_in = 32'(NUM_SEGS);
      applyStimulus("sel out of range");
      cfgWrite(3, 0, 64'h40);
      modeStep(1'b1, 1'b0, "enter user 4");
      clearInputs();
      bus.dm_req     = 1'b1;
      bus.dm_addr_in = 26'h4;
      bus.im_req     = 1'b1;
      bus.im_addr_in = 26'h10;
      applyStimulus("seg3 still active");
      modeStep(1'b0, 1'b1, "back to kernel");

      for (int cyc = 0; cyc < 600; cyc++) begin
         clearInputs();
         if ($urandom_range(0, 99) < 15) begin
            rnd_field = int'($urandom_range(0, 3));
            if (rnd_field == 0 || rnd_field == 2) begin
               case ($urandom_range(0, 3))
                  0, 1:    rnd_data = longint'($urandom_range(0, 'h3000));
                  2:       rnd_data = 64'h3FFFFFF - longint'($urandom_range(0, 16));
                  default: rnd_data = longint'($urandom());
               endcase
            end else begin
               case ($urandom_range(0, 3))
                  0, 1:    rnd_data = longint'($urandom_range('h800, 'h8000));
                  2:       rnd_data = 64'h3FFFFFF;
                  default: rnd_data = longint'($urandom());
               endcase
            end
            bus.cfg_we    = 1'b1;
            bus.cfg_field = 2'(rnd_field);
            bus.cfg_sel   = ($urandom_range(0, 1) == 0) ? 4'(m_sel) : 4'($urandom_range(0, 15));
            bus.cfg_data  = 32'(rnd_data);
         end else if ($urandom_range(0, 99) < 8) begin
            bus.sel_we = 1'b1;
            bus.sel_in = 32'($urandom_range(0, 20));
         end
         bus.user_mode   = ($urandom_range(0, 3) == 0);
         bus.kernel_mode = ($urandom_range(0, 15) == 0);
         bus.im_req      = 1'($urandom_range(0, 1));
         bus.im_addr_in  = ($urandom_range(0, 7) == 0) ? 26'($urandom()) : 26'($urandom_range(0, 'h6000));
         bus.dm_req      = 1'($urandom_range(0, 1));
         bus.dm_addr_in  = ($urandom_range(0, 7) == 0) ? 26'($urandom()) : 26'($urandom_range(0, 'h6000));
         applyStimulus("random");
      end

      modeStep(1'b0, 1'b1, "kernel before reset");
      imReq(64'h55, "request before reset");
      #3;
      rst_n = 1'b0;
      #1;
      resetModel();
      checkAll("async reset");
      clearInputs();
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus("after reset");

      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end

endmodule
